// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Source indices, default sizes and the x0 address live here.
package rf_arb_pkg;

  localparam int unsigned NUM_SRC_DEFAULT = 3;
  localparam int unsigned ADDR_W_DEFAULT  = 5;
  localparam int unsigned DATA_W_DEFAULT  = 32;

  typedef logic [1:0] src_idx_t;

  localparam src_idx_t SRC_ALU = 2'd0;
  localparam src_idx_t SRC_LSU = 2'd1;
  localparam src_idx_t SRC_MDU = 2'd2;

  localparam logic [ADDR_W_DEFAULT-1:0] X0_ADDR = '0;

  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] addr;
    logic [DATA_W_DEFAULT-1:0] data;
  } rf_wr_req_t;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request bus and register-file write port between producers and the arbiter.
interface rf_write_arbiter_if #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
);
  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0][ADDR_W-1:0] src_addr;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]             src_ready;
  logic                           we3;
  logic [ADDR_W-1:0]              wa3;
  logic [DATA_W-1:0]              wd3;

  modport master (
    output src_valid, src_addr, src_data,
    input  src_ready, we3, wa3, wd3
  );

  modport slave (
    input  src_valid, src_addr, src_data,
    output src_ready, we3, wa3, wd3
  );
endinterface

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant starting the scan at ptr,
// plus the pointer value that follows the winner.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] gnt_idx,
  output logic [PTR_W-1:0] next_ptr
);

  always_comb begin
    int unsigned sum;
    logic [PTR_W-1:0] idx;
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sum       = 0;
    idx       = '0;
    for (int unsigned off = 0; off < N; off++) begin
      sum = int'(ptr) + off;
      if (sum >= N) sum = sum - N;
      idx = PTR_W'(sum);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
      end
    end
    next_ptr = (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the register file write port among writeback producers,
// with a registered write stage and a saturating contention counter.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  rf_write_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]   contention_cnt
);

  localparam int unsigned PTR_W = ptr_width(NUM_SRC);

  logic [NUM_SRC-1:0] eligible, x0_ack, req, gnt;
  logic               gnt_valid, contend;
  logic [PTR_W-1:0]   gnt_idx, next_ptr;

  logic               armed_q, armed_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               we3_q, we3_d;
  logic [ADDR_W-1:0]  wa3_q, wa3_d;
  logic [DATA_W-1:0]  wd3_q, wd3_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    int unsigned n_elig;
    eligible = '0;
    x0_ack   = '0;
    n_elig   = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      x0_ack[i]   = bus.src_valid[i] && (bus.src_addr[i] == ADDR_W'(X0_ADDR));
      eligible[i] = bus.src_valid[i] && (bus.src_addr[i] != ADDR_W'(X0_ADDR));
      n_elig      = n_elig + int'(eligible[i]);
    end
    // armed_q blanks the first cycle after reset release so requests
    // that straddled the reset are never written.
    req     = armed_q ? eligible : '0;
    contend = armed_q && (n_elig >= 2);
  end

  rr_arbiter #(
    .N     (NUM_SRC),
    .PTR_W (PTR_W)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr_q),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .next_ptr  (next_ptr)
  );

  always_comb begin
    armed_d  = 1'b1;
    rr_ptr_d = gnt_valid ? next_ptr : rr_ptr_q;
    we3_d    = gnt_valid;
    wa3_d    = gnt_valid ? bus.src_addr[gnt_idx] : wa3_q;
    wd3_d    = gnt_valid ? bus.src_data[gnt_idx] : wd3_q;
    cnt_d    = (contend && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q  <= 1'b0;
      rr_ptr_q <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      cnt_q    <= '0;
    end else begin
      armed_q  <= armed_d;
      rr_ptr_q <= rr_ptr_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.src_ready   = armed_q ? (gnt | x0_ack) : '0;
  assign bus.we3         = we3_q;
  assign bus.wa3         = wa3_q;
  assign bus.wd3         = wd3_q;
  assign contention_cnt  = cnt_q;

endmodule
